// File: rtl/handshake_rx_fifo.sv
// Valid/ready receive slave with a first-word-fall-through FIFO and a programmable
// post-accept recovery gap. Define HS_RX_STATS_EN to add the 16-bit beat_cnt output.
module handshake_rx_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
`ifdef HS_RX_STATS_EN
    ,
    output logic [15:0]              beat_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic [3:0]        gap_q,    gap_d;
    logic [DATA_W-1:0] last_q,   last_d;

    logic push;
    logic pop;

    // Ready depends only on registered state so upstream sees no valid->ready path.
    assign in_ready  = !rst && (level_q != LVL_FULL) && (gap_q == 4'd0);
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = level_q;

    // When empty, present the most recently popped word rather than stale memory.
    assign out_data  = out_valid ? mem[rd_ptr_q] : last_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        gap_d    = gap_q;
        last_d   = last_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = mem[rd_ptr_q];
        end

        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        if (push) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            gap_q    <= GAP_LOAD;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
        end
    end

    // Storage is deliberately left unreset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

`ifdef HS_RX_STATS_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (push) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
